// File: rtl/stream_to_bram_capture.sv
`default_nettype none
// ============================================================================
//  Module   : stream_to_bram_capture
//  Purpose  : Captures an AXI-Stream sample stream into a BRAM write port.
//             Once armed, every accepted beat is written one cycle later as
//             {tlast, zero fill, tdata}. Capture stops when the buffer of
//             2^BRAM_DEPTH_BITS words is full. Any beat that arrives after
//             that point is dropped and sets a sticky overflow flag.
//  Options  : STREAM_TO_BRAM_SYNC_TLAST_EN
//             When defined, an armed capture first discards beats up to and
//             including the first tlast beat. Capture therefore starts on a
//             frame boundary.
//  Ports    : s00_axis_aclk/areset - clock, async active-high reset
//             s00_axis_t*          - stream sink (tstrb ignored)
//             arm                  - one-cycle capture start pulse
//             bram_addr/dataout/we - registered BRAM write port
//             capture_done         - buffer full
//             capture_count        - words written in this capture
//             overflow             - sticky, beat dropped after full
//  Notes    : BRAM_TDATA_WIDTH must be at least C_S00_AXIS_TDATA_WIDTH + 1.
//  Revision : 1.0 - initial release
// ============================================================================
module stream_to_bram_capture #(
   parameter int BRAM_DEPTH_BITS        = 10,
   parameter int C_S00_AXIS_TDATA_WIDTH = 48,
   parameter int BRAM_TDATA_WIDTH       = 64
) (
   input  logic                                s00_axis_aclk,
   input  logic                                s00_axis_areset,
   input  logic                                s00_axis_tvalid,
   input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
   input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
   input  logic                                s00_axis_tlast,
   output logic                                s00_axis_tready,
   input  logic                                arm,
   output logic [BRAM_DEPTH_BITS-1:0]          bram_addr,
   output logic [BRAM_TDATA_WIDTH-1:0]         bram_dataout,
   output logic                                bram_we,
   output logic                                capture_done,
   output logic [BRAM_DEPTH_BITS:0]            capture_count,
   output logic                                overflow
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
`ifdef STREAM_TO_BRAM_SYNC_TLAST_EN
      SYNC    = 2'd1,
`endif
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   // State entered when an arm pulse is taken.
`ifdef STREAM_TO_BRAM_SYNC_TLAST_EN
   localparam state_t c_arm_state = SYNC;
`else
   localparam state_t c_arm_state = CAPTURE;
`endif

   state_t                        r_state;
   state_t                        w_state_next;
   logic                          r_tready;
   logic                          r_we;
   logic [BRAM_DEPTH_BITS-1:0]    r_addr;
   logic [BRAM_TDATA_WIDTH-1:0]   r_dataout;
   logic [BRAM_DEPTH_BITS:0]      r_count;
   logic                          r_done;
   logic                          r_overflow;

   logic                          w_accept;
   logic                          w_write;
   logic                          w_clear;
   logic                          w_drop;
   logic                          w_last_word;
   logic [BRAM_TDATA_WIDTH-1:0]   w_word;

   // Byte strobes carry no meaning for this sink.
   logic                          w_unused_tstrb;
   assign w_unused_tstrb = ^s00_axis_tstrb;

   assign w_accept    = s00_axis_tvalid & r_tready;
   // The low address bits are all ones on the word that fills the buffer.
   assign w_last_word = &r_count[BRAM_DEPTH_BITS-1:0];

   // Place tdata in the LSBs and tlast in the MSB. All other bits are zero.
   always_comb begin
      w_word                                = '0;
      w_word[C_S00_AXIS_TDATA_WIDTH-1:0]    = s00_axis_tdata;
      w_word[BRAM_TDATA_WIDTH-1]            = s00_axis_tlast;
   end

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and datapath controls
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_write      = 1'b0;
      w_clear      = 1'b0;
      w_drop       = 1'b0;
      case (r_state)
         IDLE: begin
            // A beat that coincides with arm is discarded.
            if (arm) begin
               w_clear      = 1'b1;
               w_state_next = c_arm_state;
            end
         end
`ifdef STREAM_TO_BRAM_SYNC_TLAST_EN
         SYNC: begin
            if (w_accept && s00_axis_tlast) begin
               w_state_next = CAPTURE;
            end
         end
`endif
         CAPTURE: begin
            // tlast does not end a capture. Only a full buffer does.
            if (w_accept) begin
               w_write = 1'b1;
               if (w_last_word) begin
                  w_state_next = DONE;
               end
            end
         end
         DONE: begin
            if (arm) begin
               w_clear      = 1'b1;
               w_state_next = c_arm_state;
            end else if (w_accept) begin
               w_drop = 1'b1;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Registered BRAM write port and status
   // ------------------------------------------------------------------------
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_tready   <= 1'b0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_dataout  <= '0;
         r_count    <= '0;
         r_done     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_tready <= 1'b1;
         r_we     <= w_write;
         if (w_write) begin
            r_addr    <= r_count[BRAM_DEPTH_BITS-1:0];
            r_dataout <= w_word;
            r_count   <= r_count + 1'b1;
            if (w_last_word) begin
               r_done <= 1'b1;
            end
         end
         if (w_clear) begin
            r_count    <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign s00_axis_tready = r_tready;
   assign bram_we         = r_we;
   assign bram_addr       = r_addr;
   assign bram_dataout    = r_dataout;
   assign capture_count   = r_count;
   assign capture_done    = r_done;
   assign overflow        = r_overflow;

endmodule
`default_nettype wire
